cordic_sched: RTL and testbench

CORDIC_SCHED -- requirements
Module: cordic_sched

---
 rtl/cordic_sched.sv | 124 ++++++++++++
 tb/tb_cordic_sched.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_sched.sv
// Round-robin arbiter that shares one CORDIC core between two LFO requesters.
// One transaction in flight; a WAIT timeout returns sin=0 and raises a sticky error.
module cordic_sched #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        req0_valid,
  input  logic [31:0] req0_angle,
  output logic        req0_ready,
  output logic        resp0_valid,
  output logic [23:0] resp0_sin,
  input  logic        req1_valid,
  input  logic [31:0] req1_angle,
  output logic        req1_ready,
  output logic        resp1_valid,
  output logic [23:0] resp1_sin,
  output logic [31:0] cordic_angle,
  output logic        cordic_angle_valid,
  input  logic [23:0] cordic_sin,
  input  logic        cordic_sin_valid,
  output logic        busy,
  output logic        timeout_err,
  input  logic        err_clr
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  state_e           state_q, state_d;
  logic             rr_q, rr_d;
  logic             owner_q, owner_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [31:0]      cang_q, cang_d;
  logic             cangv_q, cangv_d;
  logic [1:0]       rvld_q, rvld_d;
  logic [1:0][23:0] rsin_q, rsin_d;
  logic             terr_q, terr_d;

  logic grant_ok, gid, terr_set;

  always_comb begin
    grant_ok = (state_q == IDLE) && en && (req0_valid || req1_valid);
    // rr only arbitrates a tie; a lone requester always wins
    gid      = (req0_valid && req1_valid) ? rr_q : req1_valid;
    state_d  = state_q;
    rr_d     = rr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    cang_d   = cang_q;
    cangv_d  = 1'b0;
    rvld_d   = 2'b00;
    rsin_d   = rsin_q;
    terr_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_ok) begin
          owner_d = gid;
          cang_d  = gid ? req1_angle : req0_angle;
          cangv_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // a result on the last allowed cycle beats the timeout
        if (cordic_sin_valid || cnt_q == CNT_LAST) begin
          rsin_d[owner_q] = cordic_sin_valid ? cordic_sin : 24'h0;
          rvld_d[owner_q] = 1'b1;
          terr_set        = !cordic_sin_valid;
          rr_d            = !owner_q;
          state_d         = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    terr_d = terr_set || (terr_q && !err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      owner_q <= 1'b0;
      cnt_q   <= '0;
      cang_q  <= '0;
      cangv_q <= 1'b0;
      rvld_q  <= '0;
      rsin_q  <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      cang_q  <= cang_d;
      cangv_q <= cangv_d;
      rvld_q  <= rvld_d;
      rsin_q  <= rsin_d;
      terr_q  <= terr_d;
    end
  end

  // ready is combinational, so gate it with reset to keep outputs low during reset
  assign req0_ready         = rst_n && grant_ok && !gid;
  assign req1_ready         = rst_n && grant_ok && gid;
  assign resp0_valid        = rvld_q[0];
  assign resp1_valid        = rvld_q[1];
  assign resp0_sin          = rsin_q[0];
  assign resp1_sin          = rsin_q[1];
  assign cordic_angle       = cang_q;
  assign cordic_angle_valid = cangv_q;
  assign busy               = (state_q != IDLE);
  assign timeout_err        = terr_q;

endmodule

// File: tb/tb_cordic_sched.sv
// Directed bench: instance a uses the default timeout, instance b uses TIMEOUT_CYC=8.
module tb_cordic_sched;
  logic clk, rst_n;
  int ntest = 0, nfail = 0;

  logic en, r0v, r1v, csv, eclr;
  logic [31:0] r0a, r1a;
  logic [23:0] csin;
  logic r0rdy, r1rdy, s0v, s1v, cangv, busy, terr;
  logic [23:0] s0, s1;
  logic [31:0] cang;

  logic en_b, r0v_b, r1v_b, csv_b, eclr_b;
  logic [31:0] r0a_b, r1a_b;
  logic [23:0] csin_b;
  logic r0rdy_b, r1rdy_b, s0v_b, s1v_b, cangv_b, busy_b, terr_b;
  logic [23:0] s0_b, s1_b;
  logic [31:0] cang_b;

  logic own;
  logic [23:0] last0, last1;

  cordic_sched dut_a (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req0_valid(r0v), .req0_angle(r0a), .req0_ready(r0rdy), .resp0_valid(s0v), .resp0_sin(s0),
    .req1_valid(r1v), .req1_angle(r1a), .req1_ready(r1rdy), .resp1_valid(s1v), .resp1_sin(s1),
    .cordic_angle(cang), .cordic_angle_valid(cangv), .cordic_sin(csin), .cordic_sin_valid(csv),
    .busy(busy), .timeout_err(terr), .err_clr(eclr));

  cordic_sched #(.TIMEOUT_CYC(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b),
    .req0_valid(r0v_b), .req0_angle(r0a_b), .req0_ready(r0rdy_b), .resp0_valid(s0v_b), .resp0_sin(s0_b),
    .req1_valid(r1v_b), .req1_angle(r1a_b), .req1_ready(r1rdy_b), .resp1_valid(s1v_b), .resp1_sin(s1_b),
    .cordic_angle(cang_b), .cordic_angle_valid(cangv_b), .cordic_sin(csin_b), .cordic_sin_valid(csv_b),
    .busy(busy_b), .timeout_err(terr_b), .err_clr(eclr_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntest++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    ntest++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; r0v = 1'b1; r1v = 1'b0; r0a = 32'h0; r1a = 32'h0;
    csv = 1'b0; csin = 24'h0; eclr = 1'b0;
    en_b = 1'b1; r0v_b = 1'b0; r1v_b = 1'b0; r0a_b = 32'h0; r1a_b = 32'h0;
    csv_b = 1'b0; csin_b = 24'h0; eclr_b = 1'b0;
    #2;
    // reset: ready must stay low even with en and a pending request
    chk1("rst_rdy0", r0rdy, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_cang", cang, 32'h0);
    chk1("rst_cangv", cangv, 1'b0);
    chk1("rst_s0v", s0v, 1'b0);
    chk("rst_s0", {8'h0, s0}, 32'h0);
    chk1("rst_terr", terr, 1'b0);
    r0v = 1'b0;
    nxt(); nxt(); rst_n = 1'b1;
    nxt();

    // single request, L=15
    r0v = 1'b1; r0a = 32'h00011284; #1;
    chk1("single_rdy0", r0rdy, 1'b1);
    chk1("single_rdy1", r1rdy, 1'b0);
    nxt(); r0v = 1'b0; #1;
    chk1("single_issue", cangv, 1'b1);
    chk("single_cang", cang, 32'h00011284);
    chk1("single_busy", busy, 1'b1);
    nxt(); #1;
    chk1("single_issue_1cyc", cangv, 1'b0);
    repeat (14) nxt();
    csv = 1'b1; csin = 24'h000123; #1;
    chk1("single_no_early_resp", s0v, 1'b0);
    nxt(); csv = 1'b0; #1;
    chk1("single_resp0v", s0v, 1'b1);
    chk("single_resp0", {8'h0, s0}, 32'h123);
    chk1("single_resp1v", s1v, 1'b0);
    chk1("single_idle", busy, 1'b0);
    chk("single_cang_hold", cang, 32'h00011284);
    // stray result while idle
    csv = 1'b1; csin = 24'h000555;
    nxt(); csv = 1'b0; #1;
    chk1("stray_s0v", s0v, 1'b0);
    chk1("stray_s1v", s1v, 1'b0);
    chk("stray_s0_hold", {8'h0, s0}, 32'h123);

    // contention after reset: 0,1,0,1
    rst_n = 1'b0; #1; rst_n = 1'b1;
    r0v = 1'b1; r1v = 1'b1; r0a = 32'h100; r1a = 32'h200;
    last0 = 24'h0; last1 = 24'h0;
    for (int k = 0; k < 4; k++) begin
      own = k[0];
      #1;
      chk1("cont_rdy0", r0rdy, own == 1'b0);
      chk1("cont_rdy1", r1rdy, own == 1'b1);
      nxt(); #1;
      chk("cont_cang", cang, own ? 32'h200 : 32'h100);
      nxt(); nxt();
      csv = 1'b1; csin = 24'(16 + k);
      if (k == 3) begin r0v = 1'b0; r1v = 1'b0; end
      nxt(); csv = 1'b0; #1;
      if (own) last1 = 24'(16 + k); else last0 = 24'(16 + k);
      chk1("cont_s0v", s0v, own == 1'b0);
      chk1("cont_s1v", s1v, own == 1'b1);
      chk("cont_s0", {8'h0, s0}, {8'h0, last0});
      chk("cont_s1", {8'h0, s1}, {8'h0, last1});
    end

    // en dropped mid-transaction
    r1v = 1'b1; r1a = 32'h300; #1;
    chk1("en_rdy1", r1rdy, 1'b1);
    nxt(); en = 1'b0; #1;
    chk("en_cang", cang, 32'h300);
    nxt(); nxt();
    csv = 1'b1; csin = 24'h000077;
    nxt(); csv = 1'b0; #1;
    chk1("en_s1v", s1v, 1'b1);
    chk("en_s1", {8'h0, s1}, 32'h77);
    chk1("en_no_rdy", r1rdy, 1'b0);
    nxt(); #1;
    chk1("en_no_rdy2", r1rdy, 1'b0);
    en = 1'b1; #1;
    chk1("en_back_rdy", r1rdy, 1'b1);
    r1v = 1'b0;

    // reset during WAIT
    nxt(); r0v = 1'b1; r0a = 32'h400; #1;
    chk1("rstw_rdy0", r0rdy, 1'b1);
    nxt(); r0v = 1'b0;
    nxt(); #1;
    chk1("rstw_busy", busy, 1'b1);
    rst_n = 1'b0; #1;
    chk1("rstw_busy0", busy, 1'b0);
    chk("rstw_cang0", cang, 32'h0);
    chk("rstw_s1", {8'h0, s1}, 32'h0);
    nxt(); rst_n = 1'b1;
    nxt(); csv = 1'b1; csin = 24'h000099;
    nxt(); csv = 1'b0; #1;
    chk1("rstw_no_s0v", s0v, 1'b0);
    chk1("rstw_no_s1v", s1v, 1'b0);
    r0v = 1'b1; r1v = 1'b1; #1;
    chk1("rstw_rr_rdy0", r0rdy, 1'b1);
    chk1("rstw_rr_rdy1", r1rdy, 1'b0);
    r0v = 1'b0; r1v = 1'b0;

    // instance b: prime resp0 with a real result
    nxt(); r0v_b = 1'b1; r0a_b = 32'h500; #1;
    chk1("b_rdy0", r0rdy_b, 1'b1);
    nxt(); r0v_b = 1'b0;
    nxt(); nxt(); csv_b = 1'b1; csin_b = 24'h000abc;
    nxt(); csv_b = 1'b0; #1;
    chk("b_prime_s0", {8'h0, s0_b}, 32'habc);

    // timeout: 8 WAIT cycles after issue, then resp with sin 0
    r0v_b = 1'b1; r0a_b = 32'h600; #1;
    chk1("to_rdy0", r0rdy_b, 1'b1);
    nxt(); r0v_b = 1'b0; #1;
    chk("to_cang", cang_b, 32'h600);
    for (int i = 1; i <= 8; i++) begin
      nxt(); #1;
      chk1("to_wait_s0v", s0v_b, 1'b0);
      chk1("to_wait_terr", terr_b, 1'b0);
    end
    nxt(); #1;
    chk1("to_s0v", s0v_b, 1'b1);
    chk("to_s0_zero", {8'h0, s0_b}, 32'h0);
    chk1("to_terr", terr_b, 1'b1);
    chk1("to_idle", busy_b, 1'b0);
    csv_b = 1'b1; csin_b = 24'h000111;
    nxt(); csv_b = 1'b0;
    nxt(); #1;
    chk1("to_stray_s0v", s0v_b, 1'b0);
    chk1("to_stray_s1v", s1v_b, 1'b0);
    chk1("to_terr_sticky", terr_b, 1'b1);
    eclr_b = 1'b1;
    nxt(); eclr_b = 1'b0; #1;
    chk1("to_clr", terr_b, 1'b0);

    // result on the final WAIT cycle wins over the timeout
    r1v_b = 1'b1; r1a_b = 32'h700; #1;
    chk1("bnd_rdy1", r1rdy_b, 1'b1);
    nxt(); r1v_b = 1'b0;
    repeat (8) nxt();
    csv_b = 1'b1; csin_b = 24'h000def; #1;
    chk1("bnd_busy", busy_b, 1'b1);
    nxt(); csv_b = 1'b0; #1;
    chk1("bnd_s1v", s1v_b, 1'b1);
    chk("bnd_s1", {8'h0, s1_b}, 32'hdef);
    chk1("bnd_terr", terr_b, 1'b0);

    // clear coinciding with a timeout leaves the flag set
    r0v_b = 1'b1; r0a_b = 32'h800; #1;
    chk1("sc_rdy0", r0rdy_b, 1'b1);
    nxt(); r0v_b = 1'b0;
    repeat (8) nxt();
    eclr_b = 1'b1;
    nxt(); eclr_b = 1'b0; #1;
    chk1("sc_terr", terr_b, 1'b1);
    chk1("sc_s0v", s0v_b, 1'b1);
    eclr_b = 1'b1;
    nxt(); eclr_b = 1'b0; #1;
    chk1("sc_clr", terr_b, 1'b0);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule
